muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Multi-cycle multiply/divide sequencer for the five-stage MIPS core. It sits beside the Execute-stage ALU and is started by the Execute-stage multiply/divide control bit. It holds the pipeline with a stall request while a 32-step radix-2 divide or a registered multiply is in progress, then presents the HI/LO result for one cycle. That result travels down the pipeline with the existing HI/LO write controls.

## Interface
Parameters:
- `DIV_STEPS`, 32: iterations per divide. Equals the operand width and is not varied.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `startE`  in  1  Execute stage holds a valid mult/multu/div/divu instruction.
- `opE`  in  2  operation select: 00 mult, 01 multu, 10 div, 11 divu.
- `srcaE`  in  32  rs operand (dividend or multiplicand).
- `srcbE`  in  32  rt operand (divisor or multiplier).
- `cancel`  in  1  pipeline flush of Execute (exception or branch squash). Aborts any operation.
- `stall_req`  out  1  hold the PC, F, D and E stages. Combinational from state and inputs.
- `busy`  out  1  FSM is not in IDLE.
- `done`  out  1  one-cycle pulse; `hi_o`/`lo_o` are valid for the instruction currently in E.
- `hi_o`  out  32  remainder (divide) or product[63:32].
- `lo_o`  out  32  quotient (divide) or product[31:0].

## Operation
- States: IDLE, MUL, DIV, SIGN, DONE.
- **IDLE:** on `startE & ~cancel`:
  - latch the operands and `opE`;
  - assert `stall_req` in the same cycle;
  - go to MUL for `opE[1]=0`;
  - for a divide with `srcbE==0`, go to DONE and load `hi_o=srcaE`, `lo_o=32'hFFFF_FFFF`;
  - for any other divide, go to DIV and load `cnt=DIV_STEPS-1`.
- **MUL:**
  - signed (00): 64-bit product of the sign-extended operands; unsigned (01): product of the zero-extended operands;
  - product registered into `hi_o`/`lo_o`; go to DONE.
- **DIV:**
  - signed divide first takes the magnitudes of both operands;
  - each cycle performs one restoring shift-subtract step on the {remainder, quotient} 64-bit register;
  - `cnt` decrements each cycle; at `cnt==0`, go to SIGN.
- **SIGN:**
  - signed divide: negate the quotient when `srca[31]^srcb[31]`, and negate the remainder when `srca[31]`;
  - unsigned: pass through;
  - load `hi_o`/`lo_o`; go to DONE.
- **DONE:**
  - `done=1`, `stall_req=0`; go to IDLE unconditionally.
  - `startE` is still high in this cycle for the same instruction and is ignored.
- `stall_req = (state==IDLE & startE & ~cancel) | (state inside {MUL, DIV, SIGN})`.
- `cancel` in any state:
  - go to IDLE at the next edge with no `done` pulse;
  - `hi_o`/`lo_o` keep their previous values;
  - `cancel` overrides a simultaneous `startE`.
- Signed overflow case `0x80000000 / 0xFFFFFFFF` gives `lo=0x80000000`, `hi=0`. No trap is raised.
- `hi_o`/`lo_o` hold the last completed result until the next completion.

## Timing
- Reset (async, `rst=0`): state IDLE, `cnt=0`, `stall_req=0`, `busy=0`, `done=0`, `hi_o=0`, `lo_o=0`. Reset asserted mid-operation aborts immediately.
- For a start in cycle T:
  - multiply: `stall_req` is high in T and T+1; `done` is high in T+2.
  - divide: `stall_req` is high T..T+33 (1 start + 32 DIV + SIGN); `done` is high in T+34.
  - divide by zero: `stall_req` is high in T only; `done` is high in T+1.
- Outputs `hi_o`/`lo_o` change only on the edge that enters DONE.
- Back-to-back operations: the next instruction reaches E at the edge after DONE, so its start is seen in IDLE at T+3 (multiply) or T+35 (divide). There is no overlap.

## Structure
- Shared package `muldiv_pkg`:
  - op encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`;
  - state enum `md_state_t`;
  - constant `DIV_STEPS=32`.
- One sub-module, `div_iter`:
  - holds the 64-bit remainder/quotient register and one shift-subtract step per enabled cycle;
  - ports: `clk`, `rst`, `load`, `step`, `dividend`, `divisor`, `rem`, `quo`.
- FSM, counter, sign fix and multiplier stay in `muldiv_seq`.

## Test plan
- `multu`, srca=0xFFFFFFFF, srcb=0x00000002 → `stall_req` high 2 cycles; `done` at T+2; hi=0x00000001, lo=0xFFFFFFFE.
- `div`, srca=-7 (0xFFFFFFF9), srcb=2 → `stall_req` high 34 cycles; `done` at T+34; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- `divu`, srcb=0, srca=0x1234 → `done` at T+1; hi=0x1234, lo=0xFFFFFFFF.
- `div` 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0x00000000; no hang.
- `divu` 100/7 with `cancel` pulsed at T+10 → IDLE at T+11; no `done`; `hi_o`/`lo_o` keep their old values. A following `mult` 3×(-4) completes with hi=0xFFFFFFFF, lo=0xFFFFFFF4.
- `rst` driven low at T+5 of a divide → all outputs 0 immediately; `stall_req` drops; a new `mult` is accepted after release.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the multiply/divide sequencer.
package muldiv_pkg;

    localparam int DIV_STEPS = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MUL  = 3'd1;
    localparam logic [2:0] ST_DIV  = 3'd2;
    localparam logic [2:0] ST_SIGN = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        MD_IDLE = ST_IDLE,
        MD_MUL  = ST_MUL,
        MD_DIV  = ST_DIV,
        MD_SIGN = ST_SIGN,
        MD_DONE = ST_DONE
    } md_state_t;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return 32'd0 - v;
    endfunction

endpackage

// File: rtl/muldiv_seq_div_iter.sv
// Restoring radix-2 divide datapath: one shift-subtract step per enabled cycle
// on the {remainder, quotient} register pair.
module div_iter
    import muldiv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [DIV_STEPS-1:0] dividend,
    input  logic [DIV_STEPS-1:0] divisor,
    output logic [DIV_STEPS-1:0] rem,
    output logic [DIV_STEPS-1:0] quo
);

    logic [DIV_STEPS-1:0] divisor_r;
    logic [DIV_STEPS:0]   shifted_s;
    logic [DIV_STEPS:0]   trial_s;

    // The shifted partial remainder can reach 33 bits; the top bit of the trial is the borrow.
    always_comb begin
        shifted_s = {rem, quo[DIV_STEPS-1]};
        trial_s   = shifted_s - {1'b0, divisor_r};
    end

    // Remainder/quotient register: load magnitudes, then one restoring step per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem       <= '0;
            quo       <= '0;
            divisor_r <= '0;
        end else if (load) begin
            rem       <= '0;
            quo       <= dividend;
            divisor_r <= divisor;
        end else if (step) begin
            if (!trial_s[DIV_STEPS]) begin
                rem <= trial_s[DIV_STEPS-1:0];
                quo <= {quo[DIV_STEPS-2:0], 1'b1};
            end else begin
                rem <= shifted_s[DIV_STEPS-1:0];
                quo <= {quo[DIV_STEPS-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide sequencer beside the Execute-stage ALU. Stalls the
// pipeline while a multiply or 32-step divide runs, then presents HI/LO for one cycle.
module muldiv_seq #(
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        startE,
    input  logic [1:0]  opE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        cancel,
    output logic        stall_req,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    import muldiv_pkg::*;

    localparam int CNT_W = $clog2(DIV_STEPS);

    md_state_t        state_r;
    md_state_t        nextState_s;
    logic [CNT_W-1:0] cnt_r;
    logic             signed_r;
    logic [31:0]      srca_r;
    logic [31:0]      srcb_r;

    logic             accept_s;
    logic             isDivE_s;
    logic             signedE_s;
    logic             divByZero_s;
    logic             divLoad_s;
    logic             divStep_s;
    logic [31:0]      magA_s;
    logic [31:0]      magB_s;
    logic [63:0]      extA_s;
    logic [63:0]      extB_s;
    logic [63:0]      product_s;
    logic [31:0]      rem_s;
    logic [31:0]      quo_s;
    logic [31:0]      remFix_s;
    logic [31:0]      quoFix_s;
    logic             resLoad_s;
    logic [31:0]      resHi_s;
    logic [31:0]      resLo_s;

    // Start decode, operand magnitudes, multiplier and divide sign fix-up.
    always_comb begin
        isDivE_s    = (opE == OP_DIV) | (opE == OP_DIVU);
        signedE_s   = (opE == OP_MULT) | (opE == OP_DIV);
        divByZero_s = (srcbE == 32'd0);
        accept_s    = rst & (state_r == MD_IDLE) & startE & ~cancel;
        divLoad_s   = accept_s & isDivE_s & ~divByZero_s;
        divStep_s   = (state_r == MD_DIV) & ~cancel;
        magA_s      = (signedE_s & srcaE[31]) ? neg32(srcaE) : srcaE;
        magB_s      = (signedE_s & srcbE[31]) ? neg32(srcbE) : srcbE;
        extA_s      = {{32{signed_r & srca_r[31]}}, srca_r};
        extB_s      = {{32{signed_r & srcb_r[31]}}, srcb_r};
        product_s   = extA_s * extB_s;
        // 0x80000000 / -1 needs no special case: its magnitude quotient negates back to itself.
        quoFix_s    = (signed_r & (srca_r[31] ^ srcb_r[31])) ? neg32(quo_s) : quo_s;
        remFix_s    = (signed_r & srca_r[31]) ? neg32(rem_s) : rem_s;
        stall_req   = accept_s | (rst & ((state_r == MD_MUL) | (state_r == MD_DIV) |
                                         (state_r == MD_SIGN)));
    end

    // Next-state and result-select logic; cancel wins over everything.
    always_comb begin
        nextState_s = state_r;
        resLoad_s   = 1'b0;
        resHi_s     = product_s[63:32];
        resLo_s     = product_s[31:0];
        if (cancel) begin
            nextState_s = MD_IDLE;
        end else begin
            case (state_r)
                MD_IDLE: begin
                    if (!accept_s) begin
                        nextState_s = MD_IDLE;
                    end else if (!isDivE_s) begin
                        nextState_s = MD_MUL;
                    end else if (divByZero_s) begin
                        nextState_s = MD_DONE;
                        resLoad_s   = 1'b1;
                        resHi_s     = srcaE;
                        resLo_s     = 32'hFFFF_FFFF;
                    end else begin
                        nextState_s = MD_DIV;
                    end
                end
                MD_MUL: begin
                    nextState_s = MD_DONE;
                    resLoad_s   = 1'b1;
                end
                MD_DIV: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        nextState_s = MD_SIGN;
                    end else begin
                        nextState_s = MD_DIV;
                    end
                end
                MD_SIGN: begin
                    nextState_s = MD_DONE;
                    resLoad_s   = 1'b1;
                    resHi_s     = remFix_s;
                    resLo_s     = quoFix_s;
                end
                MD_DONE: begin
                    nextState_s = MD_IDLE;
                end
                default: begin
                    nextState_s = MD_IDLE;
                end
            endcase
        end
    end

    // FSM, step counter, latched operands and registered status/result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= MD_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            signed_r <= 1'b0;
            srca_r   <= 32'd0;
            srcb_r   <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi_o     <= 32'd0;
            lo_o     <= 32'd0;
        end else begin
            state_r <= nextState_s;
            busy    <= (nextState_s != MD_IDLE);
            done    <= (nextState_s == MD_DONE);
            if (accept_s) begin
                signed_r <= signedE_s;
                srca_r   <= srcaE;
                srcb_r   <= srcbE;
            end
            if (divLoad_s) begin
                cnt_r <= CNT_W'(DIV_STEPS - 1);
            end else if (divStep_s) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
            if (resLoad_s) begin
                hi_o <= resHi_s;
                lo_o <= resLo_s;
            end
        end
    end

    div_iter u_div_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (divLoad_s),
        .step     (divStep_s),
        .dividend (magA_s),
        .divisor  (magB_s),
        .rem      (rem_s),
        .quo      (quo_s)
    );

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: table of operations through a scoreboard,
// plus hand-written cancel and mid-operation reset sequences.
module tb_muldiv_seq;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          stalls;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        startE;
    logic [1:0]  opE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        cancel;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int          nCmp;
    int          nFail;
    logic [31:0] prevHi;
    logic [31:0] prevLo;
    vec_t        sbQ[$];
    vec_t        vecs[14];
    vec_t        multNeg;

    muldiv_seq #(.DIV_STEPS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .startE    (startE),
        .opE       (opE),
        .srcaE     (srcaE),
        .srcbE     (srcbE),
        .cancel    (cancel),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        nCmp++;
        if (act !== want) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    // Drive one instruction as the pipeline would: startE held until the done cycle.
    task automatic runOp(input vec_t v, input string tag);
        vec_t want;
        int   cyc;
        int   stalls;
        bit   seen;
        bit   holdOk;
        @(negedge clk);
        startE = 1'b1;
        opE    = v.op;
        srcaE  = v.a;
        srcbE  = v.b;
        sbQ.push_back(v);
        cyc    = 0;
        stalls = 0;
        seen   = 1'b0;
        holdOk = 1'b1;
        while (!seen && cyc < 80) begin
            #1;
            if (stall_req) stalls++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (hi_o !== prevHi || lo_o !== prevLo) holdOk = 1'b0;
                if (cyc == 1) chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
                @(negedge clk);
                cyc++;
            end
        end
        want = sbQ.pop_front();
        if (!seen) begin
            nCmp++;
            nFail++;
            $display("FAIL %s_timeout: no done after %0d cycles, expected at %0d", tag, cyc, want.lat);
        end else begin
            chk({tag, "_latency"}, 32'(cyc), 32'(want.lat));
            chk({tag, "_stalls"}, 32'(stalls), 32'(want.stalls));
            chk({tag, "_hi"}, hi_o, want.hi);
            chk({tag, "_lo"}, lo_o, want.lo);
            chk({tag, "_hold"}, {31'd0, holdOk}, 32'd1);
        end
        @(negedge clk);
        startE = 1'b0;
        #1;
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        prevHi = want.hi;
        prevLo = want.lo;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit sawDone;
        nCmp   = 0;
        nFail  = 0;
        prevHi = 32'd0;
        prevLo = 32'd0;

        vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 2, 2};
        vecs[1]  = '{2'b00, 32'h0000_0003, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 2, 2};
        vecs[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 2, 2};
        vecs[3]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2, 2};
        vecs[4]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 2, 2};
        vecs[5]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 34};
        vecs[6]  = '{2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1, 1};
        vecs[7]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34, 34};
        vecs[8]  = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 34, 34};
        vecs[9]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34, 34};
        vecs[10] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 34, 34};
        vecs[11] = '{2'b10, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1, 1};
        vecs[12] = '{2'b11, 32'h0000_0005, 32'h0000_0009, 32'h0000_0005, 32'h0000_0000, 34, 34};
        vecs[13] = '{2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 34, 34};
        multNeg  = vecs[1];

        rst    = 1'b0;
        startE = 1'b0;
        opE    = 2'b00;
        srcaE  = 32'd0;
        srcbE  = 32'd0;
        cancel = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_stall", {31'd0, stall_req}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_hi", hi_o, 32'd0);
        chk("reset_lo", lo_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            runOp(vecs[i], $sformatf("v%0d", i));
        end

        // divu 100/7 flushed at T+10: no done, results untouched.
        @(negedge clk);
        startE = 1'b1;
        opE    = 2'b11;
        srcaE  = 32'd100;
        srcbE  = 32'd7;
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        startE = 1'b0;
        #1;
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        chk("cancel_stall", {31'd0, stall_req}, 32'd0);
        chk("cancel_hi", hi_o, prevHi);
        chk("cancel_lo", lo_o, prevLo);
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (done) sawDone = 1'b1;
        end
        chk("cancel_nodone", {31'd0, sawDone}, 32'd0);
        runOp(multNeg, "after_cancel");

        // Cancel coinciding with a start in IDLE wins.
        @(negedge clk);
        startE = 1'b1;
        cancel = 1'b1;
        opE    = 2'b00;
        srcaE  = 32'd5;
        srcbE  = 32'd6;
        #1;
        chk("cancel_start_stall", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        startE = 1'b0;
        cancel = 1'b0;
        #1;
        chk("cancel_start_busy", {31'd0, busy}, 32'd0);
        chk("cancel_start_done", {31'd0, done}, 32'd0);

        // Reset asserted at T+5 of a divide aborts immediately.
        @(negedge clk);
        startE = 1'b1;
        opE    = 2'b10;
        srcaE  = 32'hFFFF_FFF9;
        srcbE  = 32'h0000_0002;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_stall", {31'd0, stall_req}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_hi", hi_o, 32'd0);
        chk("midrst_lo", lo_o, 32'd0);
        prevHi = 32'd0;
        prevLo = 32'd0;
        @(negedge clk);
        startE = 1'b0;
        rst    = 1'b1;
        runOp(multNeg, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
